display_decoder: RTL and testbench
==================================

Name: display_decoder

Overview:
- Reverse path of the board's hex-to-7-segment driver: observes a multiplexed, active-low 7-segment bus and recovers the 4-bit hex value shown on each digit.
- Requires a pattern to be stable for ESTAVEL consecutive samples before accepting it, rejecting multiplexing glitches.
- Flags patterns outside the 16-symbol table.
- Used in the lab self-check path, so cache/memory values driven to the displays can be read back and compared on-chip.

Parameters:
- NDIG, 4, number of display digits tracked (1..4).
- ESTAVEL, 3, consecutive identical samples required to accept a pattern (2..15).

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- amostra  in  1  sample strobe; segmentos/digito are valid this cycle.
- digito  in  2  index of the digit currently driven on the bus.
- segmentos  in  [0:6]  segment lines a..g, active-low (bit 0 = a).
- limpa_erro  in  1  clears sticky erro.
- valor  out  4*NDIG  decoded nibbles; digit i at [4i+3:4i].
- valido  out  NDIG  per-digit flag: valor nibble holds an accepted valid symbol.
- novo  out  1  one-cycle pulse: a digit was updated.
- erro  out  1  sticky: an invalid pattern was accepted.
- ultimo_invalido  out  [0:6]  last accepted invalid pattern.

Behaviour:
- Reset (reset=0 at posedge): all outputs 0, FSM OCIOSO, counter 0, stored pattern/index 0. Reset mid-count discards the count.
- Decode table (segmentos a..g -> value):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3
  - 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - 0000000=8, 0001100=9, 0001000=A, 1100000=b
  - 0110001=C, 1000010=d, 0110000=E, 0111000=F
  - Any other pattern is invalid.
- FSM states: OCIOSO, CONTANDO, TRAVADO. Counter is 4 bits.
- Match: a sample matches when {digito, segmentos} equals the stored pair.
- Samples with amostra=0: no state change; gaps do not break a count.
- Sample with digito >= NDIG: ignored entirely, no state change.
- OCIOSO + sample: store pair, count=1, go CONTANDO.
- CONTANDO + matching sample with count=ESTAVEL-1: commit at this edge, go TRAVADO.
- CONTANDO + matching sample otherwise: count+1.
- CONTANDO + non-matching sample: store the new pair, count=1, stay CONTANDO.
- TRAVADO + matching sample: no action; no re-commit, no repeat novo.
- TRAVADO + non-matching sample: store pair, count=1, go CONTANDO.
- Commit, valid pattern: valor nibble[digito] <= decoded value; valido[digito] <= 1; novo=1 for exactly the cycle after the commit edge.
- Commit, invalid pattern: valor unchanged; valido[digito] <= 0; erro <= 1; ultimo_invalido <= pattern; novo=1.
- Latency: outputs update on the edge of the ESTAVEL-th consecutive matching sample. Samples on edges 1,2,3 with ESTAVEL=3 give outputs visible after edge 3.
- limpa_erro=1 clears erro next edge. If a commit sets erro on the same edge, set wins (erro=1). ultimo_invalido is not cleared by limpa_erro.
- Other digits' valor/valido are never touched by a commit.

Test Plan:
- Reset held 2 cycles with garbage inputs -> valor=0, valido=0, novo=0, erro=0, ultimo_invalido=0.
- digito=2, segmentos=0001000, amostra=1 for 3 cycles -> valor[11:8]=A, valido=0100, novo high exactly one cycle. Holding 5 more cycles -> no further novo.
- Samples 0010010,0010010,0000110,0000110,0000110 on digito=0 -> single commit valor[3:0]=3. Value 2 never committed.
- Digit 1 holds 5. Then 1111110 ×3 on digito=1 -> erro=1, valido[1]=0, valor[7:4] still 5, ultimo_invalido=1111110, novo pulses. Then limpa_erro=1 on the same edge as a fresh invalid commit -> erro stays 1.
- Samples of 0000000 on digito=3 separated by amostra=0 gaps (1,gap,1,gap,gap,1) -> commit 8 on the third sample edge.
- Two matching samples, reset=0 one cycle, then one more matching sample -> no commit. Two further samples needed (three total after reset).

Source files
------------

// File: rtl/display_decoder.sv
// display_decoder
// Watches a multiplexed, active-low 7-segment bus and recovers the hex
// value shown on each digit. A {digit, pattern} pair must be seen on
// ESTAVEL consecutive strobed samples before it is accepted, which filters
// out the glitches seen while the bus switches between digits. Accepted
// patterns outside the 16-symbol table raise a sticky error flag.
//
// Ports:
//   clock           system clock, all logic on posedge
//   reset           synchronous, active-low reset
//   amostra         sample strobe; digito/segmentos valid this cycle
//   digito          index of the digit currently driven on the bus
//   segmentos       segment lines a..g, active-low (index 0 = a)
//   limpa_erro      clears the sticky erro flag
//   valor           decoded nibbles, digit i at [4i+3:4i]
//   valido          per-digit flag: nibble holds an accepted valid symbol
//   novo            one-cycle pulse after any digit is committed
//   erro            sticky: an invalid pattern was accepted
//   ultimo_invalido last accepted invalid pattern
module display_decoder #(
   parameter int NDIG    = 4,
   parameter int ESTAVEL = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                amostra,
   input  logic [1:0]          digito,
   input  logic [0:6]          segmentos,
   input  logic                limpa_erro,
   output logic [4*NDIG-1:0]   valor,
   output logic [NDIG-1:0]     valido,
   output logic                novo,
   output logic                erro,
   output logic [0:6]          ultimo_invalido
);

   typedef enum logic [1:0] {OCIOSO, CONTANDO, TRAVADO} state_t;

   state_t          state_reg;
   logic [3:0]      count_reg;
   logic [1:0]      dig_reg;
   logic [0:6]      seg_reg;
   logic [3:0]      nib_reg [NDIG];
   logic [NDIG-1:0] valido_reg;
   logic            novo_reg;
   logic            erro_reg;
   logic [0:6]      ult_reg;

   logic [3:0]      dec_val;
   logic            dec_ok;
   logic            sample_ok;
   logic            match;
   logic            commit;

   // Pattern literals are written a..g left to right, matching index 0 = a.
   always_comb begin
      dec_ok  = 1'b1;
      dec_val = 4'h0;
      case (segmentos)
         7'b0000001: dec_val = 4'h0;
         7'b1001111: dec_val = 4'h1;
         7'b0010010: dec_val = 4'h2;
         7'b0000110: dec_val = 4'h3;
         7'b1001100: dec_val = 4'h4;
         7'b0100100: dec_val = 4'h5;
         7'b0100000: dec_val = 4'h6;
         7'b0001111: dec_val = 4'h7;
         7'b0000000: dec_val = 4'h8;
         7'b0001100: dec_val = 4'h9;
         7'b0001000: dec_val = 4'hA;
         7'b1100000: dec_val = 4'hB;
         7'b0110001: dec_val = 4'hC;
         7'b1000010: dec_val = 4'hD;
         7'b0110000: dec_val = 4'hE;
         7'b0111000: dec_val = 4'hF;
         default:    dec_ok  = 1'b0;
      endcase
   end

   // Samples addressed to digits this instance does not track are dropped
   // before they can disturb the stability counter.
   assign sample_ok = amostra && ({1'b0, digito} < 3'(NDIG));
   assign match     = (digito == dig_reg) && (segmentos == seg_reg);
   assign commit    = sample_ok && (state_reg == CONTANDO) && match &&
                      (count_reg == 4'(ESTAVEL - 1));

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg  <= OCIOSO;
         count_reg  <= 4'd0;
         dig_reg    <= 2'd0;
         seg_reg    <= 7'd0;
         valido_reg <= '0;
         novo_reg   <= 1'b0;
         erro_reg   <= 1'b0;
         ult_reg    <= 7'd0;
         for (int i = 0; i < NDIG; i++) nib_reg[i] <= 4'h0;
      end else begin
         novo_reg <= commit;

         if (commit) begin
            if (dec_ok) begin
               nib_reg[digito]    <= dec_val;
               valido_reg[digito] <= 1'b1;
            end else begin
               valido_reg[digito] <= 1'b0;
               ult_reg            <= segmentos;
            end
         end

         // A fresh invalid commit outranks a simultaneous clear request.
         if (commit && !dec_ok)
            erro_reg <= 1'b1;
         else if (limpa_erro)
            erro_reg <= 1'b0;

         if (sample_ok) begin
            case (state_reg)
               OCIOSO: begin
                  dig_reg   <= digito;
                  seg_reg   <= segmentos;
                  count_reg <= 4'd1;
                  state_reg <= CONTANDO;
               end
               CONTANDO: begin
                  if (match) begin
                     if (count_reg == 4'(ESTAVEL - 1))
                        state_reg <= TRAVADO;
                     else
                        count_reg <= count_reg + 4'd1;
                  end else begin
                     dig_reg   <= digito;
                     seg_reg   <= segmentos;
                     count_reg <= 4'd1;
                  end
               end
               TRAVADO: begin
                  // A held pattern is committed once; only a change re-arms.
                  if (!match) begin
                     dig_reg   <= digito;
                     seg_reg   <= segmentos;
                     count_reg <= 4'd1;
                     state_reg <= CONTANDO;
                  end
               end
               default: state_reg <= OCIOSO;
            endcase
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NDIG; gi++) begin : g_valor
         assign valor[4*gi +: 4] = nib_reg[gi];
      end
   endgenerate

   assign valido          = valido_reg;
   assign novo            = novo_reg;
   assign erro            = erro_reg;
   assign ultimo_invalido = ult_reg;

endmodule

// File: tb/tb_display_decoder.sv
// Directed, table-driven bench for display_decoder (NDIG=4, ESTAVEL=3).
// Each table row is one clock: inputs driven after the falling edge, all
// outputs compared 1 time unit after the following rising edge.
module tb_display_decoder;

   localparam logic [0:6] S0   = 7'b0000001;
   localparam logic [0:6] S2   = 7'b0010010;
   localparam logic [0:6] S3   = 7'b0000110;
   localparam logic [0:6] S5   = 7'b0100100;
   localparam logic [0:6] S8   = 7'b0000000;
   localparam logic [0:6] SA   = 7'b0001000;
   localparam logic [0:6] BAD  = 7'b1111110;
   localparam logic [0:6] BAD2 = 7'b1111111;

   logic        clock;
   logic        reset;
   logic        amostra;
   logic [1:0]  digito;
   logic [0:6]  segmentos;
   logic        limpa_erro;
   logic [15:0] valor;
   logic [3:0]  valido;
   logic        novo;
   logic        erro;
   logic [0:6]  ultimo_invalido;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic        rst;
      logic        amo;
      logic [1:0]  dig;
      logic [0:6]  seg;
      logic        clr;
      logic [15:0] e_valor;
      logic [3:0]  e_valido;
      logic        e_novo;
      logic        e_erro;
      logic [0:6]  e_ult;
   } vec_t;

   vec_t tbl[$];

   display_decoder #(.NDIG(4), .ESTAVEL(3)) dut (
      .clock           (clock),
      .reset           (reset),
      .amostra         (amostra),
      .digito          (digito),
      .segmentos       (segmentos),
      .limpa_erro      (limpa_erro),
      .valor           (valor),
      .valido          (valido),
      .novo            (novo),
      .erro            (erro),
      .ultimo_invalido (ultimo_invalido)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic add(input logic rst, input logic amo, input logic [1:0] dig,
                      input logic [0:6] seg, input logic clr,
                      input logic [15:0] ev, input logic [3:0] evd,
                      input logic en, input logic ee, input logic [0:6] eu);
      vec_t v;
      v.rst = rst; v.amo = amo; v.dig = dig; v.seg = seg; v.clr = clr;
      v.e_valor = ev; v.e_valido = evd; v.e_novo = en; v.e_erro = ee;
      v.e_ult = eu;
      tbl.push_back(v);
   endtask

   // Apply one cycle of inputs and compare every output afterwards.
   task automatic step(input string name, input vec_t v);
      @(negedge clock);
      reset      = v.rst;
      amostra    = v.amo;
      digito     = v.dig;
      segmentos  = v.seg;
      limpa_erro = v.clr;
      @(posedge clock);
      #1;
      tests_run++;
      if (valor !== v.e_valor || valido !== v.e_valido || novo !== v.e_novo ||
          erro !== v.e_erro || ultimo_invalido !== v.e_ult) begin
         tests_failed++;
         $display("FAIL %s: got valor=%h valido=%b novo=%b erro=%b ult=%b, want valor=%h valido=%b novo=%b erro=%b ult=%b",
                  name, valor, valido, novo, erro, ultimo_invalido,
                  v.e_valor, v.e_valido, v.e_novo, v.e_erro, v.e_ult);
      end else begin
         $display("[TB] %s ok: valor=%h valido=%b novo=%b erro=%b ult=%b",
                  name, valor, valido, novo, erro, ultimo_invalido);
      end
   endtask

   initial begin
      vec_t v;
      reset = 1'b0; amostra = 1'b0; digito = 2'd0; segmentos = 7'd0;
      limpa_erro = 1'b0;

      // Reset held two cycles with garbage on the inputs.
      add(0, 1, 2'd1, 7'b1010101, 1, 16'h0000, 4'b0000, 0, 0, 7'd0);
      add(0, 1, 2'd2, SA,         0, 16'h0000, 4'b0000, 0, 0, 7'd0);
      // Digit 2 shows A: commit on the third sample.
      add(1, 1, 2'd2, SA, 0, 16'h0000, 4'b0000, 0, 0, 7'd0);
      add(1, 1, 2'd2, SA, 0, 16'h0000, 4'b0000, 0, 0, 7'd0);
      add(1, 1, 2'd2, SA, 0, 16'h0A00, 4'b0100, 1, 0, 7'd0);
      // Held five more cycles: no re-commit.
      for (int i = 0; i < 5; i++)
         add(1, 1, 2'd2, SA, 0, 16'h0A00, 4'b0100, 0, 0, 7'd0);
      // Digit 0: 2,2 then 3,3,3 -> only 3 is committed.
      add(1, 1, 2'd0, S2, 0, 16'h0A00, 4'b0100, 0, 0, 7'd0);
      add(1, 1, 2'd0, S2, 0, 16'h0A00, 4'b0100, 0, 0, 7'd0);
      add(1, 1, 2'd0, S3, 0, 16'h0A00, 4'b0100, 0, 0, 7'd0);
      add(1, 1, 2'd0, S3, 0, 16'h0A00, 4'b0100, 0, 0, 7'd0);
      add(1, 1, 2'd0, S3, 0, 16'h0A03, 4'b0101, 1, 0, 7'd0);
      // Digit 1 holds 5.
      add(1, 1, 2'd1, S5, 0, 16'h0A03, 4'b0101, 0, 0, 7'd0);
      add(1, 1, 2'd1, S5, 0, 16'h0A03, 4'b0101, 0, 0, 7'd0);
      add(1, 1, 2'd1, S5, 0, 16'h0A53, 4'b0111, 1, 0, 7'd0);
      // Invalid pattern on digit 1: valor kept, valido cleared, erro set.
      add(1, 1, 2'd1, BAD, 0, 16'h0A53, 4'b0111, 0, 0, 7'd0);
      add(1, 1, 2'd1, BAD, 0, 16'h0A53, 4'b0111, 0, 0, 7'd0);
      add(1, 1, 2'd1, BAD, 0, 16'h0A53, 4'b0101, 1, 1, BAD);
      // Second invalid commit coincides with a clear: set wins.
      add(1, 1, 2'd1, BAD2, 0, 16'h0A53, 4'b0101, 0, 1, BAD);
      add(1, 1, 2'd1, BAD2, 0, 16'h0A53, 4'b0101, 0, 1, BAD);
      add(1, 1, 2'd1, BAD2, 1, 16'h0A53, 4'b0101, 1, 1, BAD2);
      // Clear alone drops erro; the last invalid pattern is kept.
      add(1, 0, 2'd0, S0, 1, 16'h0A53, 4'b0101, 0, 0, BAD2);
      // Digit 3 shows 8 with strobe gaps: 1,gap,1,gap,gap,1.
      add(1, 1, 2'd3, S8, 0, 16'h0A53, 4'b0101, 0, 0, BAD2);
      add(1, 0, 2'd0, S0, 0, 16'h0A53, 4'b0101, 0, 0, BAD2);
      add(1, 1, 2'd3, S8, 0, 16'h0A53, 4'b0101, 0, 0, BAD2);
      add(1, 0, 2'd1, S2, 0, 16'h0A53, 4'b0101, 0, 0, BAD2);
      add(1, 0, 2'd2, S3, 0, 16'h0A53, 4'b0101, 0, 0, BAD2);
      add(1, 1, 2'd3, S8, 0, 16'h8A53, 4'b1101, 1, 0, BAD2);
      add(1, 1, 2'd3, S8, 0, 16'h8A53, 4'b1101, 0, 0, BAD2);

      for (int i = 0; i < tbl.size(); i++)
         step($sformatf("vec%0d", i), tbl[i]);

      // Reset in the middle of a count discards it: two samples, reset,
      // then three more samples needed before the commit.
      v.dig = 2'd0; v.seg = S5; v.clr = 0; v.amo = 1; v.rst = 1;
      v.e_valor = 16'h8A53; v.e_valido = 4'b1101; v.e_novo = 0; v.e_erro = 0;
      v.e_ult = BAD2;
      step("pre_rst_s1", v);
      step("pre_rst_s2", v);
      v.rst = 0; v.e_valor = 16'h0000; v.e_valido = 4'b0000; v.e_ult = 7'd0;
      step("mid_rst", v);
      v.rst = 1;
      step("post_rst_s1", v);
      step("post_rst_s2", v);
      v.e_valor = 16'h0005; v.e_valido = 4'b0001; v.e_novo = 1;
      step("post_rst_s3", v);
      v.e_novo = 0;
      step("post_rst_hold", v);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Safety net so the run always ends on its own.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, tests_run=%0d", tests_run);
      $fatal(1, "timeout");
   end

endmodule
